// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types, 16 MHz default timing and colour helpers
// for the WS2812 chain driver and its bit transmitter.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } ws_state_e;

  // 16 MHz: 1.25 us bit, 0.375 / 0.8125 us highs, 300 us latch
  localparam int DEF_BIT_CYC   = 20;
  localparam int DEF_T0H_CYC   = 6;
  localparam int DEF_T1H_CYC   = 13;
  localparam int DEF_RESET_CYC = 4800;

  // {R,G,B} register order -> {G,R,B} wire order
  function automatic logic [23:0] grb_reorder(
    input logic [23:0] rgb
  );
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: shapes one WS2812 data bit on the wire.
// Ports: CLK, RST (sync, high); go + bit_val start a bit;
//   dout = wire level; high_done = last high clock;
//   bit_done = last clock of the bit (go may be raised in
//   that same clock for a gapless next bit).
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC
) (
  input  logic CLK,
  input  logic RST,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic high_done,
  output logic bit_done
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] hi_len;
  logic          run;
  logic          val;
  logic          dout_q;
  logic          last;

  assign hi_len = val ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign last   = (cnt == CW'(BIT_CYC - 1));

  assign bit_done  = run & last;
  assign high_done = run & (cnt == hi_len - 1'b1);
  assign dout      = dout_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      run    <= 1'b0;
      cnt    <= '0;
      val    <= 1'b0;
      dout_q <= 1'b0;
    end else if (go) begin
      run    <= 1'b1;
      cnt    <= '0;
      val    <= bit_val;
      dout_q <= 1'b1;
    end else if (run) begin
      if (last) begin
        run    <= 1'b0;
        cnt    <= '0;
        dout_q <= 1'b0;
      end else begin
        cnt    <= cnt + 1'b1;
        dout_q <= (cnt + 1'b1) < hi_len;
      end
    end
  end

endmodule

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: frame buffer of NUM_LEDS RGB colours sent
// MSB-first in GRB order on DOUT, followed by a low latch gap.
// Ports: CLK, RST (sync, high); wr_en/wr_addr/wr_data write one
//   LED colour {R,G,B}; start requests a frame; busy = frame or
//   gap running; done = 1-clock pulse at gap end; DOUT = wire.
// Build option: WS2812_AUTO_REFRESH_EN repeats frames forever
//   after the first start (busy stays high until RST).
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC,
  parameter int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          DOUT
);

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = $clog2(RESET_CYC + 1);

  logic [23:0] fb [NUM_LEDS];

  ws_state_e   state, state_n;
  logic [AW-1:0] led_idx, led_idx_n;
  logic [AW-1:0] nxt_idx;
  logic [23:0]   sh, sh_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic          done_q, done_n;

  logic          wr_ok;
  logic [23:0]   raw_cur, raw_nxt;
  logic [23:0]   word_cur, word_nxt;
  logic          is_last;

  logic          go, tx_bit;
  logic          high_done, bit_done;

  assign wr_ok   = wr_en && (int'(wr_addr) < NUM_LEDS);
  assign nxt_idx = led_idx + 1'b1;
  assign is_last = (led_idx == AW'(NUM_LEDS - 1));

  always_ff @(posedge CLK) begin
    if (wr_ok) fb[wr_addr[IW-1:0]] <= wr_data;
  end

  // A write landing in the fetch cycle is forwarded so it is
  // not lost for the frame being sent.
  assign raw_cur = (wr_ok && wr_addr == led_idx) ?
                   wr_data : fb[led_idx[IW-1:0]];
  assign raw_nxt = (wr_ok && wr_addr == nxt_idx) ?
                   wr_data : fb[nxt_idx[IW-1:0]];

  assign word_cur = grb_reorder(raw_cur);
  assign word_nxt = grb_reorder(raw_nxt);

  ws2812_bit_tx #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_bit_tx (
    .CLK       (CLK),
    .RST       (RST),
    .go        (go),
    .bit_val   (tx_bit),
    .dout      (DOUT),
    .high_done (high_done),
    .bit_done  (bit_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      led_idx <= '0;
      sh      <= '0;
      bit_idx <= '0;
      lcnt    <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      led_idx <= led_idx_n;
      sh      <= sh_n;
      bit_idx <= bit_idx_n;
      lcnt    <= lcnt_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    led_idx_n = led_idx;
    sh_n      = sh;
    bit_idx_n = bit_idx;
    lcnt_n    = lcnt;
    done_n    = 1'b0;
    go        = 1'b0;
    tx_bit    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          led_idx_n = '0;
          state_n   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        go        = 1'b1;
        tx_bit    = word_cur[23];
        sh_n      = {word_cur[22:0], 1'b0};
        bit_idx_n = 5'd23;
        state_n   = ST_HIGH;
      end
      ST_HIGH: begin
        if (high_done) state_n = ST_LOW;
      end
      ST_LOW: begin
        if (bit_done) begin
          if (bit_idx != 5'd0) begin
            go        = 1'b1;
            tx_bit    = sh[23];
            sh_n      = {sh[22:0], 1'b0};
            bit_idx_n = bit_idx - 5'd1;
            state_n   = ST_HIGH;
          end else if (!is_last) begin
            // next LED fetched in the last low clock: no gap
            led_idx_n = nxt_idx;
            go        = 1'b1;
            tx_bit    = word_nxt[23];
            sh_n      = {word_nxt[22:0], 1'b0};
            bit_idx_n = 5'd23;
            state_n   = ST_HIGH;
          end else begin
            led_idx_n = '0;
            lcnt_n    = '0;
            state_n   = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (lcnt == LW'(RESET_CYC - 1)) begin
          done_n = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
          // LED0 fetched in the last gap clock so the
          // frame period is exactly the frame duration
          go        = 1'b1;
          tx_bit    = word_cur[23];
          sh_n      = {word_cur[22:0], 1'b0};
          bit_idx_n = 5'd23;
          state_n   = ST_HIGH;
`else
          state_n   = ST_IDLE;
`endif
        end else begin
          lcnt_n = lcnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: decodes DOUT pulse widths into bits and
// compares frames against a table and a colour-level model.
module tb_ws2812_chain_driver;

  localparam int NL    = 2;
  localparam int BC    = 20;
  localparam int T0    = 6;
  localparam int T1    = 13;
  localparam int RC    = 100;
  localparam int FRAME = NL * 24 * BC + RC;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        DOUT;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  ws2812_chain_driver #(
    .NUM_LEDS  (NL),
    .BIT_CYC   (BC),
    .T0H_CYC   (T0),
    .T1H_CYC   (T1),
    .RESET_CYC (RC),
    .AW        (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .DOUT    (DOUT)
  );

  logic [23:0] mdl [NL];

  typedef struct {
    logic [23:0] c0;
    logic [23:0] c1;
    logic [47:0] wire_exp;
  } vec_t;

  vec_t vecs [5];

  logic [47:0] cap_bits;
  int cap_n, cap_rise0, cap_done_t, cap_ndone;
  int cap_badw, cap_badp, cap_late;
  logic cap_busy_done;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [47:0] model_stream();
    logic [47:0] s = '0;
    int c, r, g, b;
    for (int l = 0; l < NL; l++) begin
      c = int'(mdl[l]);
      r = (c / 65536) % 256;
      g = (c / 256) % 256;
      b = c % 256;
      s = (s << 8) | 48'(g);
      s = (s << 8) | 48'(r);
      s = (s << 8) | 48'(b);
    end
    return s;
  endfunction

  task automatic write_led(input int a, input logic [23:0] d);
    @(negedge CLK);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    if (a < NL) mdl[a] = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input int xs, input int rst_at,
                           input int wr_at, input int wa,
                           input logic [23:0] wd,
                           input int limit);
    logic d, prev;
    int last_rise, w;
    cap_bits = '0;
    cap_n = 0; cap_rise0 = -1; cap_done_t = -1;
    cap_ndone = 0; cap_badw = 0; cap_badp = 0;
    cap_late = 0; cap_busy_done = 1'bx;
    prev = 1'b0; last_rise = -1;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("dout_in_load", 64'(DOUT), 64'd0);
    for (int t = 1; t <= limit; t++) begin
      @(negedge CLK);
      start = 1'b0;
      RST   = 1'b0;
      wr_en = 1'b0;
      d = DOUT;
      if (d && !prev) begin
        if (last_rise < 0) cap_rise0 = t;
        else if (t - last_rise != BC) cap_badp++;
        last_rise = t;
        if (rst_at >= 0 && t > rst_at) cap_late++;
      end
      if (!d && prev) begin
        w = t - last_rise;
        if (w == T1) cap_bits = {cap_bits[46:0], 1'b1};
        else if (w == T0) cap_bits = {cap_bits[46:0], 1'b0};
        else cap_badw++;
        cap_n++;
      end
      if (done) begin
        cap_ndone++;
        if (cap_ndone == 1) begin
          cap_done_t    = t;
          cap_busy_done = busy;
        end
      end
      if (rst_at >= 0 && t == rst_at + 1) begin
        check("rst_dout", 64'(DOUT), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
      end
      prev = d;
      if (t == xs) start = 1'b1;
      if (t == rst_at) RST = 1'b1;
      if (t == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = 2'(wa);
        wr_data = wd;
        if (wa < NL) mdl[wa] = wd;
      end
    end
  endtask

  task automatic check_frame(input string nm,
                             input logic [47:0] exp);
    check({nm, "_bits"}, 64'(cap_bits), 64'(exp));
    check({nm, "_nbits"}, 64'(cap_n), 64'd48);
    check({nm, "_widths"}, 64'(cap_badw), 64'd0);
    check({nm, "_period"}, 64'(cap_badp), 64'd0);
    check({nm, "_rise0"}, 64'(cap_rise0), 64'd1);
    check({nm, "_done_lat"}, 64'(cap_done_t - cap_rise0),
          64'(FRAME));
    check({nm, "_ndone"}, 64'(cap_ndone), 64'd1);
    check({nm, "_busy_done"}, 64'(cap_busy_done), 64'd0);
  endtask

  initial begin
    logic [47:0] exp_old;
    int dts [3];
    int nd;

    vecs[0] = '{24'hFF0000, 24'h0000FF, 48'h00FF00_0000FF};
    vecs[1] = '{24'h123456, 24'hABCDEF, 48'h341256_CDABEF};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 48'h000000_FFFFFF};
    vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 48'hA5A5A5_5A5A5A};
    vecs[4] = '{24'h00FF00, 24'h800001, 48'hFF0000_008001};

    RST = 1'b1; start = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge CLK);
    check("reset_dout", 64'(DOUT), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    RST = 1'b0;

`ifdef WS2812_AUTO_REFRESH_EN
    write_led(0, 24'hFF0000);
    write_led(1, 24'h0000FF);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    nd = 0;
    for (int t = 1; t <= 3 * FRAME + 200; t++) begin
      @(negedge CLK);
      start = (t == 1500);
      if (done) begin
        if (nd < 3) dts[nd] = t;
        nd++;
      end
    end
    start = 1'b0;
    check("auto_ndone", 64'(nd), 64'd3);
    check("auto_first", 64'(dts[0]), 64'(FRAME + 1));
    check("auto_per1", 64'(dts[1] - dts[0]), 64'(FRAME));
    check("auto_per2", 64'(dts[2] - dts[1]), 64'(FRAME));
    check("auto_busy", 64'(busy), 64'd1);
`else
    for (int i = 0; i < 5; i++) begin
      write_led(0, vecs[i].c0);
      write_led(1, vecs[i].c1);
      run_frame(-1, -1, -1, 0, 24'h0, FRAME + 100);
      check_frame($sformatf("vec%0d", i), vecs[i].wire_exp);
    end

    for (int i = 0; i < 4; i++) begin
      write_led(0, 24'($urandom));
      write_led(1, 24'($urandom));
      run_frame(-1, -1, -1, 0, 24'h0, FRAME + 100);
      check_frame($sformatf("rand%0d", i), model_stream());
    end

    // start mid-frame must neither restart nor queue
    run_frame(500, -1, -1, 0, 24'h0, FRAME + 250);
    check("busy_start_bits", 64'(cap_bits), 64'(model_stream()));
    check("busy_start_n", 64'(cap_n), 64'd48);
    check("busy_start_done", 64'(cap_ndone), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);

    // reset during bit 10 while DOUT is high
    run_frame(-1, 1 + 10 * BC + 3, -1, 0, 24'h0, FRAME + 100);
    check("rst_ndone", 64'(cap_ndone), 64'd0);
    check("rst_no_rise", 64'(cap_late), 64'd0);
    run_frame(-1, -1, -1, 0, 24'h0, FRAME + 100);
    check_frame("after_rst", model_stream());

    // LED1 not yet loaded: new colour shows in this frame
    write_led(1, 24'h123456);
    run_frame(-1, -1, 100, 1, 24'h00FF00, FRAME + 100);
    check_frame("wr_led1", model_stream());
    check("wr_led1_lit", 64'(cap_bits[23:0]), 64'h00FF00 << 8);

    // out-of-range addresses are dropped
    exp_old = model_stream();
    run_frame(-1, -1, 100, 2, 24'hABCDEF, FRAME + 100);
    check_frame("wr_oob2", exp_old);
    run_frame(-1, -1, 100, 3, 24'h777777, FRAME + 100);
    check_frame("wr_oob3", exp_old);

    // LED0 already loaded: change only in the next frame
    exp_old = model_stream();
    run_frame(-1, -1, 300, 0, 24'h0F1E2D, FRAME + 100);
    check_frame("wr_led0_cur", exp_old);
    run_frame(-1, -1, -1, 0, 24'h0, FRAME + 100);
    check_frame("wr_led0_nxt", model_stream());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
